// File: rtl/fpu_bus_if_q.sv
// CPU-side register front end for the FPU: cs/rd/wr bus with operand/op registers,
// a command FIFO towards the execution core and a result FIFO drained by end_ack.
module fpu_bus_if_q #(
    parameter int BUS_W  = 8,
    parameter int OPND_W = 32,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [BUS_W-1:0]  databus_in,
    output logic [BUS_W-1:0]  databus_out,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic              end_ack,
    output logic              cmd_end,
    output logic              busy,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [OPND_W-1:0] core_a,
    output logic [OPND_W-1:0] core_b,
    output logic [OP_W-1:0]   core_op,
    input  logic              core_res_valid,
    input  logic [OPND_W-1:0] core_res,
    output logic              core_res_ready
);
    localparam int NW    = OPND_W / BUS_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int CMD_W = 2 * OPND_W + OP_W;

    localparam logic [ADDR_W-1:0] ADDR_OP     = ADDR_W'(2 * NW);
    localparam logic [ADDR_W-1:0] ADDR_PUSH   = ADDR_W'(2 * NW + 1);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(3 * NW + 1);

    logic [OPND_W-1:0] a_reg;
    logic [OPND_W-1:0] b_reg;
    logic [OP_W-1:0]   op_reg;

    logic              wr_p1;
    logic              end_ack_p1;
    logic              ack_hold;
    logic              overflow;
    logic              cmd_end_p1;

    logic [CMD_W-1:0]  cmd_mem [DEPTH];
    logic [OPND_W-1:0] res_mem [DEPTH];
    logic [PW:0]       cmd_wp, cmd_rp, res_wp, res_rp;
    logic [PW+1:0]     outstanding;

    logic              cmd_empty, cmd_full, res_empty, res_full;
    logic              wr_commit, push_req, cmd_push, cmd_pop;
    logic              res_push, res_pop, ack_rise;
    logic [OPND_W-1:0] res_head;
    logic [4:0]        status;
    logic [BUS_W-1:0]  rdata;

    // Handshake and event decode
    assign cmd_empty = (cmd_wp == cmd_rp);
    assign cmd_full  = (cmd_wp[PW] != cmd_rp[PW]) && (cmd_wp[PW-1:0] == cmd_rp[PW-1:0]);
    assign res_empty = (res_wp == res_rp);
    assign res_full  = (res_wp[PW] != res_rp[PW]) && (res_wp[PW-1:0] == res_rp[PW-1:0]);

    // One commit per wr low pulse: only the first edge after wr falls counts.
    assign wr_commit = !cs && !wr && wr_p1;
    assign push_req  = wr_commit && (addr == ADDR_PUSH);
    assign cmd_pop   = core_valid && core_ready;
    assign cmd_push  = push_req && (!cmd_full || cmd_pop);
    assign res_push  = core_res_valid && core_res_ready;
    assign ack_rise  = end_ack && !end_ack_p1;
    assign res_pop   = ack_rise && !res_empty;

    assign core_valid     = !cmd_empty;
    assign core_res_ready = !res_full;
    assign {core_a, core_b, core_op} = cmd_mem[cmd_rp[PW-1:0]];
    assign res_head = res_empty ? '0 : res_mem[res_rp[PW-1:0]];
    assign status   = {overflow, res_full, res_empty, cmd_full, cmd_empty};
    assign busy     = core_valid || (outstanding != '0);
    assign cmd_end  = cmd_end_p1;

    // Bus register writes
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            overflow <= 1'b0;
        end else if (wr_commit) begin
            for (int k = 0; k < NW; k++) begin
                if (addr == ADDR_W'(k))
                    a_reg[k*BUS_W +: BUS_W] <= databus_in;
                if (addr == ADDR_W'(NW + k))
                    b_reg[k*BUS_W +: BUS_W] <= databus_in;
            end
            if (addr == ADDR_OP)
                op_reg <= databus_in[OP_W-1:0];
            if (addr == ADDR_STATUS)
                overflow <= 1'b0;
            else if (push_req && cmd_full && !cmd_pop)
                overflow <= 1'b1;
        end
    end

    // FIFO storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wp[PW-1:0]] <= {a_reg, b_reg, op_reg};
        if (res_push)
            res_mem[res_wp[PW-1:0]] <= core_res;
    end

    // Control state: pointers, outstanding count, strobe/ack sampling
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cmd_wp      <= '0;
            cmd_rp      <= '0;
            res_wp      <= '0;
            res_rp      <= '0;
            outstanding <= '0;
            wr_p1       <= 1'b1;
            end_ack_p1  <= 1'b0;
            ack_hold    <= 1'b0;
            cmd_end_p1  <= 1'b0;
        end else begin
            wr_p1      <= wr;
            end_ack_p1 <= end_ack;
            if (cmd_push)
                cmd_wp <= cmd_wp + (PW+1)'(1);
            if (cmd_pop)
                cmd_rp <= cmd_rp + (PW+1)'(1);
            if (res_push)
                res_wp <= res_wp + (PW+1)'(1);
            if (res_pop)
                res_rp <= res_rp + (PW+1)'(1);
            case ({cmd_pop, res_push})
                2'b10:   outstanding <= outstanding + (PW+2)'(1);
                2'b01:   outstanding <= outstanding - (PW+2)'(1);
                default: outstanding <= outstanding;
            endcase
            if (ack_rise)
                ack_hold <= 1'b1;
            else if (!end_ack)
                ack_hold <= 1'b0;
            // Dropping cmd_end while ack_hold is set gives the CPU an edge per result.
            cmd_end_p1 <= !res_empty && !ack_hold;
        end
    end

    // Read mux
    always_comb begin
        rdata = '0;
        if (arst_n && !cs && !rd) begin
            for (int k = 0; k < NW; k++) begin
                if (addr == ADDR_W'(k))
                    rdata = a_reg[k*BUS_W +: BUS_W];
                if (addr == ADDR_W'(NW + k))
                    rdata = b_reg[k*BUS_W +: BUS_W];
                if (addr == ADDR_W'(2 * NW + 1 + k))
                    rdata = res_head[k*BUS_W +: BUS_W];
            end
            if (addr == ADDR_OP)
                rdata = BUS_W'(op_reg);
            if (addr == ADDR_STATUS)
                rdata = BUS_W'(status);
        end
    end

    assign databus_out = rdata;

endmodule

// File: tb/tb_fpu_bus_if_q.sv
// Bench for fpu_bus_if_q: a byte-wide instance with a latency-10 core model and
// a word-wide DEPTH=2 instance driven by hand for backpressure.
module tb_fpu_bus_if_q;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Byte-wide instance
    logic [7:0]  databus_in = '0;
    logic [7:0]  databus_out;
    logic [3:0]  addr = '0;
    logic        cs = 1'b1, rd = 1'b1, wr = 1'b1, end_ack = 1'b0;
    logic        cmd_end, busy, core_valid, core_res_ready;
    logic        core_ready = 1'b0;
    logic        core_res_valid = 1'b0;
    logic [31:0] core_a, core_b;
    logic [31:0] core_res = '0;
    logic [3:0]  core_op;

    fpu_bus_if_q #(.BUS_W(8), .OPND_W(32), .OP_W(4), .DEPTH(4), .ADDR_W(4)) dut8 (
        .clk(clk), .arst_n(arst_n), .databus_in(databus_in), .databus_out(databus_out),
        .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end),
        .busy(busy), .core_valid(core_valid), .core_ready(core_ready), .core_a(core_a),
        .core_b(core_b), .core_op(core_op), .core_res_valid(core_res_valid),
        .core_res(core_res), .core_res_ready(core_res_ready)
    );

    // Word-wide instance
    logic [31:0] w_databus_in = '0;
    logic [31:0] w_databus_out;
    logic [3:0]  w_addr = '0;
    logic        w_cs = 1'b1, w_rd = 1'b1, w_wr = 1'b1, w_end_ack = 1'b0;
    logic        w_cmd_end, w_busy, w_core_valid, w_core_res_ready;
    logic        w_core_ready = 1'b0;
    logic        w_core_res_valid = 1'b0;
    logic [31:0] w_core_a, w_core_b;
    logic [31:0] w_core_res = '0;
    logic [3:0]  w_core_op;

    fpu_bus_if_q #(.BUS_W(32), .OPND_W(32), .OP_W(4), .DEPTH(2), .ADDR_W(4)) dut32 (
        .clk(clk), .arst_n(arst_n), .databus_in(w_databus_in), .databus_out(w_databus_out),
        .addr(w_addr), .cs(w_cs), .rd(w_rd), .wr(w_wr), .end_ack(w_end_ack),
        .cmd_end(w_cmd_end), .busy(w_busy), .core_valid(w_core_valid),
        .core_ready(w_core_ready), .core_a(w_core_a), .core_b(w_core_b), .core_op(w_core_op),
        .core_res_valid(w_core_res_valid), .core_res(w_core_res),
        .core_res_ready(w_core_res_ready)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } cmd_t;

    typedef struct {
        logic [31:0] res;
        int          due;
    } pend_t;

    typedef struct {
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    cmd_t        cmd_sb[$];
    logic [31:0] res_sb[$];
    pend_t       pend[$];
    int          cyc = 0;
    int          hs_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Core model: op 2 scales A by a power-of-two B via exponent add, else passes A.
    function automatic logic [31:0] core_fn(input cmd_t c);
        if (c.op == 4'd2)
            return c.a + c.b - 32'h3f80_0000;
        return c.a;
    endfunction

    always @(negedge clk) begin
        #2;
        cyc++;
        if (!arst_n) begin
            pend.delete();
            core_res_valid = 1'b0;
        end else begin
            if (core_res_valid && core_res_ready)
                core_res_valid = 1'b0;
            if (core_valid && core_ready) begin
                cmd_t e;
                cmd_t got;
                hs_cnt++;
                got = {core_a, core_b, core_op};
                if (cmd_sb.size() == 0) begin
                    check("core_cmd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = cmd_sb.pop_front();
                    check("core_a", core_a, e.a);
                    check("core_b", core_b, e.b);
                    check("core_op", 32'(core_op), 32'(e.op));
                end
                pend.push_back('{core_fn(got), cyc + 10});
            end
            if (!core_res_valid && pend.size() > 0 && pend[0].due <= cyc) begin
                core_res = pend[0].res;
                core_res_valid = 1'b1;
                void'(pend.pop_front());
            end
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
        @(negedge clk);
        wr = 1'b1; cs = 1'b1;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; cs = 1'b0; rd = 1'b0;
        #1 d = databus_out;
        rd = 1'b1; cs = 1'b1;
    endtask

    task automatic set_a(input logic [31:0] v);
        for (int k = 0; k < 4; k++)
            bus_wr(4'(k), v[k*8 +: 8]);
    endtask

    task automatic push_cmd(input cmd_t c, input logic [31:0] exp_res);
        cmd_sb.push_back(c);
        res_sb.push_back(exp_res);
        bus_wr(4'd9, 8'h00);
    endtask

    task automatic check_status(input string nm, input logic [7:0] exp);
        logic [7:0] s;
        bus_rd(4'd13, s);
        check(nm, 32'(s), 32'(exp));
    endtask

    task automatic wait_cmd_end(input string nm);
        int n = 0;
        while (!cmd_end && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(cmd_end), 32'd1);
    endtask

    task automatic check_res(input string nm);
        logic [7:0]  b;
        logic [31:0] v;
        for (int k = 0; k < 4; k++) begin
            bus_rd(4'(9 + k), b);
            v[k*8 +: 8] = b;
        end
        if (res_sb.size() == 0)
            check({nm, "_unexpected"}, v, 32'hxxxx_xxxx);
        else
            check(nm, v, res_sb.pop_front());
    endtask

    task automatic ack8(input string nm);
        logic saw_low = 1'b0;
        @(negedge clk);
        end_ack = 1'b1;
        @(negedge clk);
        end_ack = 1'b0;
        if (!cmd_end) saw_low = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (!cmd_end) saw_low = 1'b1;
        end
        check(nm, 32'(saw_low), 32'd1);
    endtask

    task automatic w_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        w_addr = a; w_databus_in = d; w_cs = 1'b0; w_wr = 1'b0;
        @(negedge clk);
        w_wr = 1'b1; w_cs = 1'b1;
    endtask

    task automatic w_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        w_addr = a; w_cs = 1'b0; w_rd = 1'b0;
        #1 d = w_databus_out;
        w_rd = 1'b1; w_cs = 1'b1;
    endtask

    task automatic w_ack();
        @(negedge clk);
        w_end_ack = 1'b1;
        @(negedge clk);
        w_end_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [20];
        logic [7:0]  r;
        logic [31:0] w;
        logic [31:0] bb_vals [3];
        int          hs0;
        int          n;

        vt[0]  = '{1'b1, 4'd0,  8'h0d, 8'h00};
        vt[1]  = '{1'b1, 4'd1,  8'h89, 8'h00};
        vt[2]  = '{1'b1, 4'd2,  8'h96, 8'h00};
        vt[3]  = '{1'b1, 4'd3,  8'h4d, 8'h00};
        vt[4]  = '{1'b1, 4'd4,  8'h00, 8'h00};
        vt[5]  = '{1'b1, 4'd5,  8'h00, 8'h00};
        vt[6]  = '{1'b1, 4'd6,  8'h00, 8'h00};
        vt[7]  = '{1'b1, 4'd7,  8'h40, 8'h00};
        vt[8]  = '{1'b1, 4'd8,  8'hf2, 8'h00};
        vt[9]  = '{1'b0, 4'd0,  8'h00, 8'h0d};
        vt[10] = '{1'b0, 4'd3,  8'h00, 8'h4d};
        vt[11] = '{1'b0, 4'd7,  8'h00, 8'h40};
        vt[12] = '{1'b0, 4'd8,  8'h00, 8'h02};
        vt[13] = '{1'b0, 4'd13, 8'h00, 8'h05};
        vt[14] = '{1'b1, 4'd10, 8'hff, 8'h00};
        vt[15] = '{1'b0, 4'd10, 8'h00, 8'h00};
        vt[16] = '{1'b0, 4'd14, 8'h00, 8'h00};
        vt[17] = '{1'b0, 4'd15, 8'h00, 8'h00};
        vt[18] = '{1'b0, 4'd5,  8'h00, 8'h00};
        vt[19] = '{1'b0, 4'd2,  8'h00, 8'h96};
        bb_vals[0] = 32'h3f80_0000;
        bb_vals[1] = 32'h4000_0000;
        bb_vals[2] = 32'h4120_0000;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_databus_out", 32'(databus_out), 32'd0);
        check("rst_cmd_end", 32'(cmd_end), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_valid", 32'(core_valid), 32'd0);
        check("rst_core_res_ready", 32'(core_res_ready), 32'd1);
        @(negedge clk);
        arst_n = 1'b1;

        // Register map vectors; leaves A=0x4d96890d, B=0x40000000, OP=2
        for (int i = 0; i < 20; i++) begin
            if (vt[i].wr) begin
                bus_wr(vt[i].a, vt[i].d);
            end else begin
                bus_rd(vt[i].a, r);
                check($sformatf("vec%0d_addr%0d", i, vt[i].a), 32'(r), 32'(vt[i].exp));
            end
        end

        // Single multiply
        core_ready = 1'b1;
        push_cmd({32'h4d96_890d, 32'h4000_0000, 4'd2}, 32'h4e16_890d);
        check("mul_busy", 32'(busy), 32'd1);
        wait_cmd_end("mul_cmd_end");
        check_res("mul_result");
        ack8("mul_ack_edge");
        check("mul_cmd_end_after_ack", 32'(cmd_end), 32'd0);
        check("mul_busy_after_ack", 32'(busy), 32'd0);

        // Command queue fill with the core stalled
        core_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_cmd({32'h4d96_890d, 32'h4000_0000, 4'd2}, 32'h4e16_890d);
        check_status("fill_status_full", 8'h06);
        bus_wr(4'd9, 8'h00);
        check_status("fill_status_overflow", 8'h16);
        bus_wr(4'd13, 8'h00);
        check_status("fill_status_cleared", 8'h06);
        hs0 = hs_cnt;
        @(negedge clk);
        core_ready = 1'b1;
        repeat (30) @(negedge clk);
        check("fill_drained_cmds", 32'(hs_cnt - hs0), 32'd4);
        check("fill_core_valid_low", 32'(core_valid), 32'd0);
        check_status("fill_status_res_full", 8'h09);
        for (int i = 0; i < 4; i++) begin
            wait_cmd_end($sformatf("fill_cmd_end%0d", i));
            check_res($sformatf("fill_result%0d", i));
            ack8($sformatf("fill_ack_edge%0d", i));
        end
        check_status("fill_status_empty", 8'h05);

        // Back-to-back results
        bus_wr(4'd8, 8'h00);
        for (int i = 0; i < 3; i++) begin
            set_a(bb_vals[i]);
            push_cmd({bb_vals[i], 32'h4000_0000, 4'd0}, bb_vals[i]);
        end
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_busy_drop", 32'(busy), 32'd0);
        check_status("b2b_status_pending", 8'h01);
        for (int i = 0; i < 3; i++) begin
            wait_cmd_end($sformatf("b2b_cmd_end%0d", i));
            check_res($sformatf("b2b_result%0d", i));
            ack8($sformatf("b2b_ack_edge%0d", i));
        end
        check_status("b2b_status_empty", 8'h05);

        // Reset with commands queued and one in flight
        set_a(32'h1122_3344);
        push_cmd({32'h1122_3344, 32'h4000_0000, 4'd0}, 32'h1122_3344);
        repeat (2) @(negedge clk);
        core_ready = 1'b0;
        push_cmd({32'h1122_3344, 32'h4000_0000, 4'd0}, 32'h1122_3344);
        push_cmd({32'h1122_3344, 32'h4000_0000, 4'd0}, 32'h1122_3344);
        check("mid_core_valid", 32'(core_valid), 32'd1);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("mid_rst_cmd_end", 32'(cmd_end), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_core_valid", 32'(core_valid), 32'd0);
        check("mid_rst_core_res_ready", 32'(core_res_ready), 32'd1);
        check("mid_rst_databus_out", 32'(databus_out), 32'd0);
        cmd_sb.delete();
        res_sb.delete();
        @(negedge clk);
        arst_n = 1'b1;
        check_status("mid_status_after_rst", 8'h05);
        bus_rd(4'd0, r);
        check("mid_a_cleared", 32'(r), 32'd0);
        repeat (20) @(negedge clk);
        check("mid_no_result", 32'(cmd_end), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

        // Word-wide instance: single command
        w_write(4'd0, 32'h4216_8f5c);
        w_write(4'd1, 32'h4000_0000);
        w_write(4'd2, 32'h0000_0000);
        w_write(4'd3, 32'h0000_0000);
        check("w_core_valid", 32'(w_core_valid), 32'd1);
        check("w_core_a", w_core_a, 32'h4216_8f5c);
        check("w_core_b", w_core_b, 32'h4000_0000);
        check("w_busy", 32'(w_busy), 32'd1);
        @(negedge clk);
        w_core_ready = 1'b1;
        @(negedge clk);
        w_core_ready = 1'b0;
        check("w_core_valid_popped", 32'(w_core_valid), 32'd0);
        w_core_res = 32'h4216_8f5c;
        w_core_res_valid = 1'b1;
        @(negedge clk);
        w_core_res_valid = 1'b0;
        @(negedge clk);
        check("w_cmd_end", 32'(w_cmd_end), 32'd1);
        w_read(4'd3, w);
        check("w_result", w, 32'h4216_8f5c);
        w_read(4'd4, w);
        check("w_status_pending", w, 32'h0000_0001);
        w_ack();
        w_read(4'd4, w);
        check("w_status_empty", w, 32'h0000_0005);
        check("w_busy_idle", 32'(w_busy), 32'd0);

        // Word-wide instance: result backpressure at DEPTH=2
        w_core_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            w_write(4'd3, 32'h0000_0000);
        repeat (2) @(negedge clk);
        w_core_ready = 1'b0;
        check("bp_cmds_taken", 32'(w_core_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            w_core_res = bb_vals[i];
            w_core_res_valid = 1'b1;
        end
        @(negedge clk);
        w_core_res = bb_vals[2];
        @(negedge clk);
        check("bp_ready_low", 32'(w_core_res_ready), 32'd0);
        w_end_ack = 1'b1;
        @(negedge clk);
        check("bp_ready_after_ack", 32'(w_core_res_ready), 32'd1);
        w_end_ack = 1'b0;
        @(negedge clk);
        w_core_res_valid = 1'b0;
        w_read(4'd4, w);
        check("bp_status_full_again", w, 32'h0000_0009);
        w_read(4'd3, w);
        check("bp_result1", w, bb_vals[1]);
        w_ack();
        w_read(4'd3, w);
        check("bp_result2", w, bb_vals[2]);
        w_ack();
        w_read(4'd4, w);
        check("bp_status_empty", w, 32'h0000_0005);
        check("bp_busy_idle", 32'(w_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
